cnn_infer_ctrl: RTL and testbench

Inference sequencer that sits in front of mnist_cnn in place of a free-running input source. On a host start it clears the CNN, streams one 28x28 8-bit image at a time from an external synchronous image ROM, waits for the CNN decision, and reports it. It repeats this for a programmed number of images, then signals done. A watchdog aborts the batch if the CNN never answers.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/cnn_pix_pipe.sv | 36 +++
 rtl/cnn_infer_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cnn_infer_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Constants and the sequencer state type. mnist_cnn and input_module share
// the image geometry and decision width defined here.
package cnn_pkg;

    localparam int PIX_W   = 8;
    localparam int IMG_PIX = 784;
    localparam int DEC_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_WAIT,
        ST_REPORT,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/cnn_pix_pipe.sv
// Aligns ROM read data with its enable. Pixels reach the CNN two cycles after
// their rom_en, and anything already in flight drains normally on abort.
module cnn_pix_pipe
    import cnn_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rom_en_i,
    input  logic [PIX_W-1:0] rom_data_i,
    output logic             pix_valid_o,
    output logic [PIX_W-1:0] pix_data_o
);

    logic             en_q;
    logic             valid_q;
    logic [PIX_W-1:0] data_q;

    // en_q lines up with the cycle in which the synchronous ROM presents data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            en_q    <= rom_en_i;
            valid_q <= en_q;
            if (en_q) begin
                data_q <= rom_data_i;
            end
        end
    end

    assign pix_valid_o = valid_q;
    assign pix_data_o  = data_q;

endmodule

// File: rtl/cnn_infer_ctrl.sv
// Inference sequencer: for each image of a batch it clears the CNN, streams the
// image from ROM, waits (with watchdog) for the decision and reports it.
module cnn_infer_ctrl
    import cnn_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int ADDR_W  = 14,
    parameter int CLR_CYC = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [IDX_W-1:0]  num_img_m1_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_timeout_o,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [PIX_W-1:0]  rom_data_i,
    output logic              cnn_clr_n_o,
    output logic [PIX_W-1:0]  pix_data_o,
    output logic              pix_valid_o,
    input  logic              cnn_valid_i,
    input  logic [DEC_W-1:0]  cnn_decision_i,
    output logic              res_valid_o,
    output logic [DEC_W-1:0]  res_decision_o,
    output logic [IDX_W-1:0]  res_idx_o
);

    localparam int PCNT_W = $clog2(IMG_PIX);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam int CCNT_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    state_e              state_q;
    logic [PCNT_W-1:0]   pix_cnt_q;
    logic [WCNT_W-1:0]   wait_cnt_q;
    logic [WCNT_W-1:0]   wait_cnt_d;
    logic [CCNT_W-1:0]   clr_cnt_q;
    logic                drain_q;
    logic [IDX_W-1:0]    img_idx_q;
    logic [IDX_W-1:0]    num_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                rom_en_q;
    logic                cnn_clr_n_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                res_valid_q;
    logic [DEC_W-1:0]    res_dec_q;
    logic [IDX_W-1:0]    res_idx_q;

    assign wait_cnt_d = (wait_cnt_q == WCNT_W'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + 1'b1;

    // Every output is a register updated on the transition into the state that owns it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            pix_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            clr_cnt_q   <= '0;
            drain_q     <= 1'b0;
            img_idx_q   <= '0;
            num_q       <= '0;
            rom_addr_q  <= '0;
            rom_en_q    <= 1'b0;
            cnn_clr_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_dec_q   <= '0;
            res_idx_q   <= '0;
        end else begin
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            if (abort_i && state_q != ST_IDLE && state_q != ST_FINISH) begin
                state_q     <= ST_FINISH;
                rom_en_q    <= 1'b0;
                cnn_clr_n_q <= 1'b1;
                done_q      <= 1'b1;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            state_q     <= ST_CLEAR;
                            num_q       <= num_img_m1_i;
                            err_q       <= 1'b0;
                            img_idx_q   <= '0;
                            rom_addr_q  <= '0;
                            clr_cnt_q   <= '0;
                            cnn_clr_n_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        if (clr_cnt_q == CCNT_W'(CLR_CYC - 1)) begin
                            state_q     <= ST_STREAM;
                            cnn_clr_n_q <= 1'b1;
                            rom_en_q    <= 1'b1;
                            pix_cnt_q   <= '0;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 1'b1;
                        end
                    end
                    // rom_addr keeps counting across images so image i starts at i*IMG_PIX.
                    ST_STREAM: begin
                        rom_addr_q <= rom_addr_q + 1'b1;
                        if (pix_cnt_q == PCNT_W'(IMG_PIX - 1)) begin
                            state_q  <= ST_DRAIN;
                            rom_en_q <= 1'b0;
                            drain_q  <= 1'b0;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_q) begin
                            state_q    <= ST_WAIT;
                            wait_cnt_q <= '0;
                        end else begin
                            drain_q <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        wait_cnt_q <= wait_cnt_d;
                        if (cnn_valid_i) begin
                            state_q     <= ST_REPORT;
                            res_valid_q <= 1'b1;
                            res_dec_q   <= cnn_decision_i;
                            res_idx_q   <= img_idx_q;
                        end else if (wait_cnt_d == WCNT_W'(TIMEOUT)) begin
                            state_q <= ST_FINISH;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_REPORT: begin
                        if (img_idx_q == num_q) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= ST_CLEAR;
                            img_idx_q   <= img_idx_q + 1'b1;
                            clr_cnt_q   <= '0;
                            cnn_clr_n_q <= 1'b0;
                        end
                    end
                    ST_FINISH: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    cnn_pix_pipe u_pix_pipe (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rom_en_i    (rom_en_q),
        .rom_data_i  (rom_data_i),
        .pix_valid_o (pix_valid_o),
        .pix_data_o  (pix_data_o)
    );

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_timeout_o  = err_q;
    assign rom_en_o       = rom_en_q;
    assign rom_addr_o     = rom_addr_q;
    assign cnn_clr_n_o    = cnn_clr_n_q;
    assign res_valid_o    = res_valid_q;
    assign res_decision_o = res_dec_q;
    assign res_idx_o      = res_idx_q;

endmodule

// File: tb/tb_cnn_infer_ctrl.sv
// Bench for cnn_infer_ctrl: a ROM and CNN model drive the sequencer while a
// monitor condenses its outputs into event lists checked per directed step.
module tb_cnn_infer_ctrl;

    localparam int IMG_PIX = 784;
    localparam int TIMEOUT = 4096;
    localparam int ROM_SZ  = 16384;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [3:0]  numImgM1;
    logic        abort;
    logic        busy;
    logic        done;
    logic        errTimeout;
    logic        romEn;
    logic [13:0] romAddr;
    logic [7:0]  romData;
    logic        cnnClrN;
    logic [7:0]  pixData;
    logic        pixValid;
    logic        cnnValid;
    logic [3:0]  cnnDecision;
    logic        resValid;
    logic [3:0]  resDecision;
    logic [3:0]  resIdx;

    logic [7:0]  romMem [0:ROM_SZ-1];

    int cyc = 0;
    int passCnt = 0;
    int failCnt = 0;
    int checkCnt = 0;
    int ans [0:63];
    int ansWr = 0;
    int cnnMode = 1;
    int cnnLat = 10;
    int spurCyc = -1;

    int pvTotal = 0, pixErr = 0, addrErr = 0;
    int rsCyc[$], rsAddr[$], rl[$], clCyc[$], clLen[$];
    int pvCyc[$], pvFirst[$], pvLen[$];
    int resCyc[$], resDec[$], resIdxQ[$];
    int dnCyc[$], dnBusy[$], dnErr[$];

    int bRs, bCl, bPv, bRes, bDn, bPixErr, bAddrErr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (romEn) romData <= romMem[romAddr];
    end

    cnn_infer_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .start_i        (start),
        .num_img_m1_i   (numImgM1),
        .abort_i        (abort),
        .busy_o         (busy),
        .done_o         (done),
        .err_timeout_o  (errTimeout),
        .rom_en_o       (romEn),
        .rom_addr_o     (romAddr),
        .rom_data_i     (romData),
        .cnn_clr_n_o    (cnnClrN),
        .pix_data_o     (pixData),
        .pix_valid_o    (pixValid),
        .cnn_valid_i    (cnnValid),
        .cnn_decision_i (cnnDecision),
        .res_valid_o    (resValid),
        .res_decision_o (resDecision),
        .res_idx_o      (resIdx)
    );

    // Monitor plus CNN model: the k-th pixel of a batch must be ROM[k], and the
    // CNN answers a fixed latency after its 784th pixel since the last clear.
    initial begin
        int expAddr = 0, pixInImg = 0, pend = 0, pendCyc = 0, pendDec = 0, ansRd = 0;
        int reRun = 0, pvRun = 0, clRun = 0;
        logic rePrev = 1'b0, pvPrev = 1'b0, clPrev = 1'b0, busyPrev = 1'b0;
        cnnValid = 1'b0;
        cnnDecision = 4'd0;
        forever begin
            @(negedge clk);
            cyc++;
            cnnValid = 1'b0;
            if (!rstN) begin
                pend = 0;
                pixInImg = 0;
            end
            if (busy && !busyPrev) expAddr = 0;
            if (!cnnClrN) begin
                pixInImg = 0;
                pend = 0;
                if (clPrev) clRun++;
                else begin
                    clCyc.push_back(cyc);
                    clRun = 1;
                end
            end else if (clPrev) clLen.push_back(clRun);
            if (romEn) begin
                if (!rePrev) begin
                    rsCyc.push_back(cyc);
                    rsAddr.push_back(int'(romAddr));
                    reRun = 0;
                end
                if (int'(romAddr) != rsAddr[rsAddr.size()-1] + reRun) addrErr++;
                reRun++;
            end else if (rePrev) rl.push_back(reRun);
            if (pixValid) begin
                if (!pvPrev) begin
                    pvCyc.push_back(cyc);
                    pvFirst.push_back(int'(pixData));
                    pvRun = 0;
                end
                pvRun++;
                pvTotal++;
                if (pixData !== romMem[expAddr % ROM_SZ]) pixErr++;
                expAddr++;
                pixInImg++;
                if (pixInImg == IMG_PIX) begin
                    pixInImg = 0;
                    if (cnnMode != 0) begin
                        pend = 1;
                        pendCyc = cyc + cnnLat;
                        pendDec = ans[ansRd % 64];
                        ansRd++;
                    end
                end
            end else if (pvPrev) pvLen.push_back(pvRun);
            if (resValid) begin
                resCyc.push_back(cyc);
                resDec.push_back(int'(resDecision));
                resIdxQ.push_back(int'(resIdx));
            end
            if (done) begin
                dnCyc.push_back(cyc);
                dnBusy.push_back(int'(busy));
                dnErr.push_back(int'(errTimeout));
            end
            if (pend != 0 && cyc == pendCyc) begin
                cnnValid = 1'b1;
                cnnDecision = 4'(pendDec);
                pend = 0;
            end else if (cyc == spurCyc) begin
                cnnValid = 1'b1;
                cnnDecision = 4'd5;
            end
            rePrev = romEn;
            pvPrev = pixValid;
            clPrev = !cnnClrN;
            busyPrev = busy;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic snap();
        bRs = rsCyc.size();  bCl = clCyc.size(); bPv = pvCyc.size();
        bRes = resCyc.size(); bDn = dnCyc.size();
        bPixErr = pixErr; bAddrErr = addrErr;
    endtask

    task automatic pushAns(input int d);
        ans[ansWr % 64] = d;
        ansWr++;
    endtask

    task automatic applyStimulus(input logic [3:0] n, output int t0);
        numImgM1 = n;
        start = 1'b1;
        t0 = cyc;
        tick(1);
        start = 1'b0;
        numImgM1 = 4'($urandom_range(0, 15));
    endtask

    task automatic waitDone(input int target, input int budget, input string tag);
        int k = 0;
        while (dnCyc.size() < target && k < budget) begin
            tick(1);
            k++;
        end
        checkOutput(tag, int'(dnCyc.size() >= target), 1);
        tick(3);
    endtask

    task automatic fillRom(input logic randomFill);
        for (int a = 0; a < ROM_SZ; a++) romMem[a] = randomFill ? 8'($urandom) : 8'(a);
    endtask

    initial begin
        int t0, n, d, abCyc, pvSnap, k;
        rstN = 1'b0; start = 1'b0; abort = 1'b0; numImgM1 = 4'd0;
        fillRom(1'b0);
        tick(3);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err", int'(errTimeout), 0);
        checkOutput("rst_rom_en", int'(romEn), 0);
        checkOutput("rst_rom_addr", int'(romAddr), 0);
        checkOutput("rst_clr_n", int'(cnnClrN), 1);
        checkOutput("rst_pix", int'({pixValid, pixData}), 0);
        checkOutput("rst_res", int'({resValid, resDecision, resIdx}), 0);
        rstN = 1'b1;
        tick(2);

        $display("[TB] step 1: single image");
        snap(); pushAns(7); cnnLat = 10;
        applyStimulus(4'd0, t0);
        waitDone(bDn + 1, 3000, "t1_done_seen");
        checkOutput("t1_clr_start", clCyc[bCl] - t0, 1);
        checkOutput("t1_clr_len", clLen[bCl], 2);
        checkOutput("t1_rom_first_cyc", rsCyc[bRs] - t0, 3);
        checkOutput("t1_rom_first_addr", rsAddr[bRs], 0);
        checkOutput("t1_rom_run", rl[bRs], IMG_PIX);
        checkOutput("t1_pix_first_cyc", pvCyc[bPv] - t0, 5);
        checkOutput("t1_pix_first_data", pvFirst[bPv], 0);
        checkOutput("t1_pix_run", pvLen[bPv], IMG_PIX);
        checkOutput("t1_pix_data_err", pixErr - bPixErr, 0);
        checkOutput("t1_addr_err", addrErr - bAddrErr, 0);
        checkOutput("t1_res_count", resCyc.size() - bRes, 1);
        checkOutput("t1_res_dec", resDec[bRes], 7);
        checkOutput("t1_res_idx", resIdxQ[bRes], 0);
        checkOutput("t1_res_cyc", resCyc[bRes] - t0, 5 + IMG_PIX - 1 + 10 + 1);
        checkOutput("t1_done_cyc", dnCyc[bDn] - resCyc[bRes], 1);
        checkOutput("t1_done_busy", dnBusy[bDn], 0);
        checkOutput("t1_busy_after", int'(busy), 0);

        $display("[TB] step 2: three images");
        fillRom(1'b1);
        snap(); pushAns(3); pushAns(9); pushAns(0); cnnLat = $urandom_range(1, 30);
        applyStimulus(4'd2, t0);
        waitDone(bDn + 1, 6000, "t2_done_seen");
        checkOutput("t2_res_count", resCyc.size() - bRes, 3);
        checkOutput("t2_done_count", dnCyc.size() - bDn, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t2_rom_addr%0d", i), rsAddr[bRs+i], i * IMG_PIX);
            checkOutput($sformatf("t2_clr_before%0d", i), rsCyc[bRs+i] - clCyc[bCl+i], 2);
            checkOutput($sformatf("t2_res_idx%0d", i), resIdxQ[bRes+i], i);
        end
        checkOutput("t2_res_dec0", resDec[bRes], 3);
        checkOutput("t2_res_dec1", resDec[bRes+1], 9);
        checkOutput("t2_res_dec2", resDec[bRes+2], 0);
        checkOutput("t2_pix_data_err", pixErr - bPixErr, 0);

        $display("[TB] step 3: timeout");
        snap(); cnnMode = 0;
        applyStimulus(4'd0, t0);
        waitDone(bDn + 1, 6000, "t3_done_seen");
        checkOutput("t3_done_cyc", dnCyc[bDn] - t0, 5 + IMG_PIX - 1 + 1 + TIMEOUT);
        checkOutput("t3_err_at_done", dnErr[bDn], 1);
        checkOutput("t3_no_result", resCyc.size() - bRes, 0);
        checkOutput("t3_err_sticky", int'(errTimeout), 1);
        checkOutput("t3_busy", int'(busy), 0);
        snap(); cnnMode = 1; d = $urandom_range(0, 9); pushAns(d);
        applyStimulus(4'd0, t0);
        checkOutput("t3_err_cleared", int'(errTimeout), 0);
        waitDone(bDn + 1, 3000, "t3b_done_seen");
        checkOutput("t3b_res_dec", resDec[bRes], d);

        $display("[TB] step 4: abort");
        snap();
        applyStimulus(4'd3, t0);
        while (cyc < t0 + 3 + 100) tick(1);
        abort = 1'b1; abCyc = cyc; pvSnap = pvTotal;
        tick(1);
        abort = 1'b0;
        checkOutput("t4_rom_en_off", int'(romEn), 0);
        waitDone(bDn + 1, 50, "t4_done_seen");
        checkOutput("t4_done_cyc", dnCyc[bDn] - abCyc, 1);
        checkOutput("t4_rom_run", rl[bRs], 101);
        checkOutput("t4_tail_le2", int'(pvTotal - pvSnap <= 2), 1);
        checkOutput("t4_no_result", resCyc.size() - bRes, 0);
        checkOutput("t4_busy", int'(busy), 0);
        checkOutput("t4_pix_data_err", pixErr - bPixErr, 0);

        $display("[TB] step 5: ignored inputs");
        snap(); d = $urandom_range(0, 8); if (d >= 5) d++; pushAns(d); cnnLat = $urandom_range(1, 30);
        applyStimulus(4'd0, t0);
        spurCyc = t0 + 300;
        while (cyc < t0 + 200) tick(1);
        start = 1'b1; numImgM1 = 4'd15;
        tick(1);
        start = 1'b0;
        waitDone(bDn + 1, 3000, "t5_done_seen");
        checkOutput("t5_res_count", resCyc.size() - bRes, 1);
        checkOutput("t5_res_dec", resDec[bRes], d);
        checkOutput("t5_images", rsCyc.size() - bRs, 1);
        checkOutput("t5_done_count", dnCyc.size() - bDn, 1);
        spurCyc = -1;

        $display("[TB] step 6: async reset");
        snap(); cnnLat = 40; pushAns($urandom_range(1, 9)); pushAns($urandom_range(0, 9));
        applyStimulus(4'd1, t0);
        k = 0;
        while (pvLen.size() < bPv + 2 && k < 4000) begin
            tick(1);
            k++;
        end
        tick(15);
        checkOutput("t6_pre_busy", int'(busy), 1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("t6_busy", int'(busy), 0);
        checkOutput("t6_rom_addr", int'(romAddr), 0);
        checkOutput("t6_res_dec", int'(resDecision), 0);
        checkOutput("t6_clr_n", int'(cnnClrN), 1);
        checkOutput("t6_flags", int'({done, resValid, pixValid, romEn, errTimeout}), 0);
        tick(3);
        rstN = 1'b1;
        tick(5);
        checkOutput("t6_no_done", dnCyc.size() - bDn, 0);
        checkOutput("t6_one_result", resCyc.size() - bRes, 1);
        snap(); d = $urandom_range(0, 9); pushAns(d); cnnLat = 10;
        applyStimulus(4'd0, t0);
        waitDone(bDn + 1, 3000, "t6b_done_seen");
        checkOutput("t6b_rom_addr", rsAddr[bRs], 0);
        checkOutput("t6b_res_dec", resDec[bRes], d);

        $display("[TB] step 7: random batch");
        fillRom(1'b1);
        snap(); n = $urandom_range(0, 3); cnnLat = $urandom_range(1, 30);
        for (int i = 0; i <= n; i++) pushAns($urandom_range(0, 9));
        applyStimulus(4'(n), t0);
        waitDone(bDn + 1, 8000, "t7_done_seen");
        checkOutput("t7_res_count", resCyc.size() - bRes, n + 1);
        for (int i = 0; i <= n; i++) begin
            checkOutput($sformatf("t7_rom_addr%0d", i), rsAddr[bRs+i], i * IMG_PIX);
            checkOutput($sformatf("t7_res_dec%0d", i), resDec[bRes+i], ans[(ansWr - n - 1 + i) % 64]);
            checkOutput($sformatf("t7_res_idx%0d", i), resIdxQ[bRes+i], i);
        end
        checkOutput("t7_pix_data_err", pixErr - bPixErr, 0);
        checkOutput("t7_addr_err", addrErr - bAddrErr, 0);

        $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
